// File: rtl/simulate_adc_thru_ddr3_async_pkg.sv
// Shared constants, header layout and acquisition FSM states for the ASYNC CBUF model.
package simulate_adc_thru_ddr3_async_pkg;

   localparam int unsigned CbufAwDefault = 11;
   localparam int unsigned BurstW        = 128;
   localparam int unsigned HdrW          = 152;

   // Fill header field LSB positions
   localparam int unsigned HdrFillLsb  = 128;
   localparam int unsigned HdrTagLsb   = 112;
   localparam int unsigned HdrPreLsb   = 100;
   localparam int unsigned HdrLenLsb   = 89;
   localparam int unsigned HdrStartLsb = 66;
   localparam int unsigned HdrTsLsb    = 34;
   localparam int unsigned HdrCntLsb   = 26;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StCapture
   } acq_state_e;

   // 16-bit CBUF word for one ADC sample
   function automatic logic [15:0] sample_word(input logic [11:0] smp, input logic ovr);
      return {3'b000, ovr, smp};
   endfunction

endpackage

// File: rtl/simulate_adc_thru_ddr3_async_cbuf_ram.sv
// Simple dual-port synchronous RAM, read-first on same-address collision.
module simulate_adc_thru_ddr3_async_cbuf_ram #(
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 128
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   // Storage write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; sees the pre-write contents on a collision
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/simulate_adc_thru_ddr3_async.sv
// ASYNC waveform acquisition into a circular burst buffer, with a replay readout port.
module simulate_adc_thru_ddr3_async
   import simulate_adc_thru_ddr3_async_pkg::*;
#(
   parameter int unsigned CBUF_AW = CbufAwDefault
) (
   input  logic          clk125,
   input  logic          rst_from_master,
   input  logic [11:0]   adc_in_p,
   input  logic          adc_dovrp,
   input  logic [15:0]   channel_tag,
   input  logic [23:0]   initial_fill_num,
   input  logic          initial_fill_num_wr,
   input  logic [10:0]   async_num_bursts,
   input  logic [11:0]   async_pre_trig,
   input  logic          acq_enable0,
   input  logic          acq_enable1,
   input  logic          acq_trig,
   input  logic [22:0]   ddr3_rd_start_addr,
   input  logic [23:0]   ddr3_rd_burst_cnt,
   input  logic          enable_reading,
   output logic [23:0]   fill_num,
   output logic          acq_done,
   output logic [151:0]  fill_header_fifo_out,
   output logic [127:0]  ddr3_rd_fifo_input_dat,
   output logic          ddr3_rd_fifo_input_wr,
   output logic          reading_done
);

   // Edge detection
   logic armed, armed_q, armed_rise, armed_fall;
   logic trig_q, trig_q2, trig_edge;
   logic rd_en_q, rd_rise;

   // Burst assembly / write side
   logic [2:0]          phase_q, phase_d;
   logic [111:0]        burst_q, burst_d;
   logic [15:0]         word;
   logic                we;
   logic [BurstW-1:0]   wdata;
   logic [CBUF_AW-1:0]  wr_ptr_q, wr_ptr_d;

   // Capture FSM
   acq_state_e          state_q, state_d;
   logic [CBUF_AW-1:0]  start_q, start_d, stop_q, stop_d;
   logic [31:0]         ts_q, ts_d, ts_lat_q, ts_lat_d;
   logic [7:0]          trig_cnt_q, trig_cnt_d;
   logic [23:0]         fill_num_q, fill_num_d;
   logic [HdrW-1:0]     hdr_q, hdr_d;
   logic                acq_done_c;
   logic [10:0]         pre_ext, pre_eff;
   logic [CBUF_AW-1:0]  pre_aw, len_aw;

   // Readout
   logic                reading_q, reading_d;
   logic [CBUF_AW-1:0]  rd_addr_q, rd_addr_d;
   logic [23:0]         rd_left_q, rd_left_d;
   logic                rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
   logic                rd_done_q, rd_done_d;
   logic                rd_re;
   logic                unused_rd_addr_hi;

   assign armed      = acq_enable0 | acq_enable1;
   assign armed_rise = armed & ~armed_q;
   assign armed_fall = ~armed & armed_q;
   assign trig_edge  = trig_q & ~trig_q2;
   assign rd_rise    = enable_reading & ~rd_en_q;
   assign word       = sample_word(adc_in_p, adc_dovrp);

   // Pre-trigger in bursts, clamped so the window always ends after the trigger burst
   assign pre_ext = {2'b00, async_pre_trig[11:3]};
   assign pre_eff = (pre_ext >= async_num_bursts) ? async_num_bursts - 11'd1 : pre_ext;
   assign pre_aw  = CBUF_AW'(pre_eff);
   assign len_aw  = CBUF_AW'(async_num_bursts);

   assign unused_rd_addr_hi = ^ddr3_rd_start_addr[22:CBUF_AW];

   // Burst assembly: collect words 0..6, write the burst when word 7 arrives
   always_comb begin
      phase_d = armed ? phase_q + 3'd1 : 3'd0;
      burst_d = burst_q;
      for (int k = 0; k < 7; k++) begin
         if (armed && (phase_q == 3'(k))) begin
            burst_d[16*k +: 16] = word;
         end
      end
      we       = armed && (phase_q == 3'd7);
      wdata    = {word, burst_q};
      wr_ptr_d = we ? wr_ptr_q + CBUF_AW'(1) : wr_ptr_q;
   end

   // Capture FSM, timestamp, fill number and header assembly
   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      stop_d     = stop_q;
      ts_lat_d   = ts_lat_q;
      trig_cnt_d = trig_cnt_q;
      hdr_d      = hdr_q;
      acq_done_c = 1'b0;

      if (armed_rise) begin
         ts_d = '0;
      end else if (armed) begin
         ts_d = ts_q + 32'd1;
      end else begin
         ts_d = ts_q;
      end

      if (initial_fill_num_wr) begin
         fill_num_d = initial_fill_num;
      end else if (armed_fall) begin
         fill_num_d = fill_num_q + 24'd1;
      end else begin
         fill_num_d = fill_num_q;
      end

      unique case (state_q)
         StIdle: begin
            if (armed_rise) begin
               state_d    = StArmed;
               trig_cnt_d = '0;
            end
         end
         StArmed: begin
            if (trig_edge && (async_num_bursts != 11'd0)) begin
               state_d  = StCapture;
               start_d  = wr_ptr_q - pre_aw;
               stop_d   = wr_ptr_q - pre_aw + len_aw;
               ts_lat_d = ts_q;
            end
         end
         StCapture: begin
            if (we && (wr_ptr_q == stop_q - CBUF_AW'(1))) begin
               state_d    = StArmed;
               acq_done_c = 1'b1;
               trig_cnt_d = trig_cnt_q + 8'd1;
               hdr_d      = '0;
               hdr_d[HdrFillLsb +: 24]       = fill_num_q;
               hdr_d[HdrTagLsb +: 16]        = channel_tag;
               hdr_d[HdrPreLsb +: 12]        = async_pre_trig;
               hdr_d[HdrLenLsb +: 11]        = async_num_bursts;
               hdr_d[HdrStartLsb +: CBUF_AW] = start_q;
               hdr_d[HdrTsLsb +: 32]         = ts_lat_q;
               hdr_d[HdrCntLsb +: 8]         = trig_cnt_q;
            end
         end
         default: state_d = StIdle;
      endcase

      // Disarm wins over everything; an unfinished capture is dropped silently
      if (!armed) begin
         state_d = StIdle;
      end
   end

   // Readout sequencer: one RAM read per cycle, data valid one cycle later
   always_comb begin
      reading_d  = reading_q;
      rd_addr_d  = rd_addr_q;
      rd_left_d  = rd_left_q;
      rd_done_d  = rd_done_q;
      rd_re      = reading_q & enable_reading;
      rd_valid_d = rd_re;
      rd_last_d  = rd_re && (rd_left_q == 24'd1);

      if (!enable_reading) begin
         reading_d = 1'b0;
         rd_done_d = 1'b0;
      end else if (rd_rise) begin
         if (ddr3_rd_burst_cnt == 24'd0) begin
            rd_done_d = 1'b1;
         end else begin
            reading_d = 1'b1;
            rd_addr_d = ddr3_rd_start_addr[CBUF_AW-1:0];
            rd_left_d = ddr3_rd_burst_cnt;
         end
      end else begin
         if (reading_q) begin
            rd_addr_d = rd_addr_q + CBUF_AW'(1);
            rd_left_d = rd_left_q - 24'd1;
            if (rd_left_q == 24'd1) begin
               reading_d = 1'b0;
            end
         end
         if (rd_valid_q && rd_last_q) begin
            rd_done_d = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk125) begin
      if (rst_from_master) begin
         armed_q    <= 1'b0;
         trig_q     <= 1'b0;
         trig_q2    <= 1'b0;
         rd_en_q    <= 1'b0;
         phase_q    <= '0;
         burst_q    <= '0;
         wr_ptr_q   <= '0;
         state_q    <= StIdle;
         start_q    <= '0;
         stop_q     <= '0;
         ts_q       <= '0;
         ts_lat_q   <= '0;
         trig_cnt_q <= '0;
         fill_num_q <= '0;
         hdr_q      <= '0;
         reading_q  <= 1'b0;
         rd_addr_q  <= '0;
         rd_left_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_done_q  <= 1'b0;
      end else begin
         armed_q    <= armed;
         trig_q     <= acq_trig;
         trig_q2    <= trig_q;
         rd_en_q    <= enable_reading;
         phase_q    <= phase_d;
         burst_q    <= burst_d;
         wr_ptr_q   <= wr_ptr_d;
         state_q    <= state_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         ts_q       <= ts_d;
         ts_lat_q   <= ts_lat_d;
         trig_cnt_q <= trig_cnt_d;
         fill_num_q <= fill_num_d;
         hdr_q      <= hdr_d;
         reading_q  <= reading_d;
         rd_addr_q  <= rd_addr_d;
         rd_left_q  <= rd_left_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_done_q  <= rd_done_d;
      end
   end

   simulate_adc_thru_ddr3_async_cbuf_ram #(
      .AW (CBUF_AW),
      .DW (BurstW)
   ) u_cbuf_ram (
      .clk_i   (clk125),
      .rst_i   (rst_from_master),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .re_i    (rd_re),
      .raddr_i (rd_addr_q),
      .rdata_o (ddr3_rd_fifo_input_dat)
   );

   assign fill_num              = fill_num_q;
   assign acq_done              = acq_done_c;
   assign fill_header_fifo_out  = hdr_q;
   assign ddr3_rd_fifo_input_wr = rd_valid_q;
   assign reading_done          = rd_done_q;

endmodule

// File: tb/tb_simulate_adc_thru_ddr3_async.sv
// Scoreboard bench: stimulus queues expected headers / readout bursts, a monitor compares.
module tb_simulate_adc_thru_ddr3_async;

   localparam int Depth = 2048;

   logic          clk125 = 1'b0;
   logic          rst_from_master = 1'b1;
   logic [11:0]   adc_in_p = '0;
   logic          adc_dovrp = 1'b0;
   logic [15:0]   channel_tag = '0;
   logic [23:0]   initial_fill_num = '0;
   logic          initial_fill_num_wr = 1'b0;
   logic [10:0]   async_num_bursts = '0;
   logic [11:0]   async_pre_trig = '0;
   logic          acq_enable0 = 1'b0;
   logic          acq_enable1 = 1'b0;
   logic          acq_trig = 1'b0;
   logic [22:0]   ddr3_rd_start_addr = '0;
   logic [23:0]   ddr3_rd_burst_cnt = '0;
   logic          enable_reading = 1'b0;
   logic [23:0]   fill_num;
   logic          acq_done;
   logic [151:0]  fill_header_fifo_out;
   logic [127:0]  ddr3_rd_fifo_input_dat;
   logic          ddr3_rd_fifo_input_wr;
   logic          reading_done;

   simulate_adc_thru_ddr3_async dut (
      .clk125                 (clk125),
      .rst_from_master        (rst_from_master),
      .adc_in_p               (adc_in_p),
      .adc_dovrp              (adc_dovrp),
      .channel_tag            (channel_tag),
      .initial_fill_num       (initial_fill_num),
      .initial_fill_num_wr    (initial_fill_num_wr),
      .async_num_bursts       (async_num_bursts),
      .async_pre_trig         (async_pre_trig),
      .acq_enable0            (acq_enable0),
      .acq_enable1            (acq_enable1),
      .acq_trig               (acq_trig),
      .ddr3_rd_start_addr     (ddr3_rd_start_addr),
      .ddr3_rd_burst_cnt      (ddr3_rd_burst_cnt),
      .enable_reading         (enable_reading),
      .fill_num               (fill_num),
      .acq_done               (acq_done),
      .fill_header_fifo_out   (fill_header_fifo_out),
      .ddr3_rd_fifo_input_dat (ddr3_rd_fifo_input_dat),
      .ddr3_rd_fifo_input_wr  (ddr3_rd_fifo_input_wr),
      .reading_done           (reading_done)
   );

   always #5 clk125 = ~clk125;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk125) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Free-running ADC ramp; over-range toggles with bit 4
   initial begin
      forever begin
         @(posedge clk125);
         #1;
         adc_in_p  = adc_in_p + 12'd1;
         adc_dovrp = adc_in_p[4];
      end
   end

   // Reference model of the buffer contents, write pointer and timestamp
   logic [127:0] m_mem [Depth];
   logic [127:0] m_burst;
   logic [2:0]   m_phase;
   logic [10:0]  m_wr_ptr;
   logic [31:0]  m_ts;
   logic         m_armed_q;

   always @(posedge clk125) begin
      if (rst_from_master) begin
         m_phase   <= '0;
         m_wr_ptr  <= '0;
         m_ts      <= '0;
         m_armed_q <= 1'b0;
      end else begin
         m_armed_q <= acq_enable0 | acq_enable1;
         if (acq_enable0 | acq_enable1) begin
            m_burst[m_phase*16 +: 16] <= {3'b000, adc_dovrp, adc_in_p};
            m_phase <= m_phase + 3'd1;
            if (m_phase == 3'd7) begin
               m_mem[m_wr_ptr] <= {3'b000, adc_dovrp, adc_in_p, m_burst[111:0]};
               m_wr_ptr <= m_wr_ptr + 11'd1;
            end
            m_ts <= m_armed_q ? m_ts + 32'd1 : 32'd0;
         end else begin
            m_phase <= '0;
         end
      end
   end

   // Scoreboard
   logic [151:0] hdr_exp_q [$];
   logic [127:0] rd_exp_q [$];
   logic [151:0] hdr_cur;
   logic [151:0] hdr_last = '0;
   logic         hdr_pend = 1'b0;
   int           n_done = 0;
   int           done_cyc = 0;
   int           n_rd = 0;
   int           rd_first_cyc = -1;

   initial begin
      forever begin
         @(negedge clk125);
         if (hdr_pend) begin
            chk("header", fill_header_fifo_out, hdr_cur);
            hdr_pend = 1'b0;
         end
         if (acq_done) begin
            n_done++;
            done_cyc = cyc;
            if (hdr_exp_q.size() == 0) begin
               chk("acq_done_unexpected", 152'(acq_done), 152'(0));
            end else begin
               hdr_cur  = hdr_exp_q.pop_front();
               hdr_pend = 1'b1;
            end
         end
         if (ddr3_rd_fifo_input_wr) begin
            n_rd++;
            if (rd_first_cyc < 0) rd_first_cyc = cyc;
            if (rd_exp_q.size() == 0) begin
               chk("rd_wr_unexpected", 152'(ddr3_rd_fifo_input_wr), 152'(0));
            end else begin
               chk("rd_data", 152'(ddr3_rd_fifo_input_dat), 152'(rd_exp_q.pop_front()));
            end
         end
      end
   end

   // Pulse the trigger; if a completion is expected, queue the header it must produce
   task automatic fire(input logic [10:0] pre_eff, input logic [23:0] fill, input logic [7:0] tcnt,
                       input bit expect_done, output logic [10:0] start, output int t0);
      logic [151:0] h;
      @(posedge clk125);
      #1;
      acq_trig = 1'b1;
      t0 = cyc;
      @(posedge clk125);
      #1;
      // Model now holds the pointer/timestamp the DUT latches on the next edge
      start = m_wr_ptr - pre_eff;
      h = {fill, channel_tag, async_pre_trig, async_num_bursts, 12'b0, start, m_ts, tcnt, 26'b0};
      if (expect_done) begin
         hdr_exp_q.push_back(h);
         hdr_last = h;
      end
      acq_trig = 1'b0;
   endtask

   task automatic wait_done(input int n0, input int budget);
      int k = 0;
      while (n_done == n0 && k < budget) begin
         @(negedge clk125);
         k++;
      end
      chk("acq_done_seen", 152'(n_done != n0), 152'(1));
      @(negedge clk125);
      @(negedge clk125);
   endtask

   task automatic do_read(input logic [10:0] addr, input int cnt);
      int n0, t0, k;
      logic [10:0] a;
      for (int i = 0; i < cnt; i++) begin
         a = addr + 11'(i);
         rd_exp_q.push_back(m_mem[a]);
      end
      ddr3_rd_start_addr = {12'b0, addr};
      ddr3_rd_burst_cnt  = 24'(cnt);
      n0 = n_rd;
      rd_first_cyc = -1;
      @(posedge clk125);
      #1;
      enable_reading = 1'b1;
      t0 = cyc;
      k = 0;
      while (!reading_done && k < cnt + 20) begin
         @(negedge clk125);
         k++;
      end
      chk("rd_done_seen", 152'(reading_done), 152'(1));
      if (cnt == 0) begin
         chk("rd_zero_immediate", 152'(cyc - t0), 152'(1));
      end else begin
         chk("rd_first_latency", 152'(rd_first_cyc - t0), 152'(2));
      end
      chk("rd_count", 152'(n_rd - n0), 152'(cnt));
      chk("rd_queue_drained", 152'(rd_exp_q.size()), 152'(0));
      repeat (3) @(negedge clk125);
      chk("rd_done_held", 152'(reading_done), 152'(1));
      @(posedge clk125);
      #1;
      enable_reading = 1'b0;
      @(negedge clk125);
      @(negedge clk125);
      chk("rd_done_clear", 152'(reading_done), 152'(0));
      rd_exp_q.delete();
   endtask

   task automatic set_arm(input bit en0, input bit en1);
      @(posedge clk125);
      #1;
      acq_enable0 = en0;
      acq_enable1 = en1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      logic [10:0] start;
      int t0, n0, k;

      // Reset
      repeat (15) @(posedge clk125);
      #1;
      rst_from_master = 1'b0;
      @(negedge clk125);
      chk("reset_fill_num", 152'(fill_num), 152'(0));
      chk("reset_acq_done", 152'(acq_done), 152'(0));
      chk("reset_header", fill_header_fifo_out, 152'(0));
      chk("reset_rd_dat", 152'(ddr3_rd_fifo_input_dat), 152'(0));
      chk("reset_rd_wr", 152'(ddr3_rd_fifo_input_wr), 152'(0));
      chk("reset_reading_done", 152'(reading_done), 152'(0));

      // Single trigger fill
      @(posedge clk125);
      #1;
      initial_fill_num    = 24'd1;
      initial_fill_num_wr = 1'b1;
      channel_tag         = 16'h0008;
      async_num_bursts    = 11'd10;
      async_pre_trig      = 12'd0;
      @(posedge clk125);
      #1;
      initial_fill_num_wr = 1'b0;
      @(negedge clk125);
      chk("fill_preload", 152'(fill_num), 152'(1));
      set_arm(1, 0);
      repeat (20) @(posedge clk125);
      n0 = n_done;
      fire(11'd0, 24'd1, 8'd0, 1'b1, start, t0);
      wait_done(n0, 300);
      chk("acq_done_latency", 152'((done_cyc - t0) >= 72 && (done_cyc - t0) <= 88), 152'(1));
      do_read(start, 10);
      set_arm(0, 0);
      repeat (2) @(negedge clk125);
      chk("fill_after_disarm1", 152'(fill_num), 152'(2));

      // Pre-trigger of 2 bursts, retrigger ignored, second trigger counts
      async_pre_trig   = 12'd16;
      async_num_bursts = 11'd4;
      set_arm(0, 1);
      repeat (30) @(posedge clk125);
      n0 = n_done;
      fire(11'd2, 24'd2, 8'd0, 1'b1, start, t0);
      repeat (3) @(posedge clk125);
      #1;
      acq_trig = 1'b1;
      @(posedge clk125);
      #1;
      acq_trig = 1'b0;
      wait_done(n0, 200);
      repeat (60) @(negedge clk125);
      chk("retrigger_ignored", 152'(n_done - n0), 152'(1));
      do_read(start, 4);
      n0 = n_done;
      fire(11'd2, 24'd2, 8'd1, 1'b1, start, t0);
      wait_done(n0, 200);
      set_arm(0, 0);
      repeat (2) @(negedge clk125);
      chk("fill_after_disarm2", 152'(fill_num), 152'(3));

      // Abort mid-capture
      async_pre_trig   = 12'd0;
      async_num_bursts = 11'd10;
      set_arm(1, 0);
      repeat (20) @(posedge clk125);
      n0 = n_done;
      fire(11'd0, 24'd3, 8'd0, 1'b0, start, t0);
      repeat (20) @(posedge clk125);
      set_arm(0, 0);
      repeat (100) @(negedge clk125);
      chk("abort_no_done", 152'(n_done - n0), 152'(0));
      chk("abort_header_kept", fill_header_fifo_out, hdr_last);
      chk("fill_after_abort", 152'(fill_num), 152'(4));

      // Wrap-around capture near the end of the buffer
      set_arm(1, 0);
      k = 0;
      while (m_wr_ptr != 11'd2044 && k < 20000) begin
         @(negedge clk125);
         k++;
      end
      chk("reach_wrap_region", 152'(m_wr_ptr), 152'(2044));
      n0 = n_done;
      fire(11'd0, 24'd4, 8'd0, 1'b1, start, t0);
      wait_done(n0, 300);
      set_arm(0, 0);
      repeat (2) @(negedge clk125);
      chk("fill_after_disarm3", 152'(fill_num), 152'(5));
      do_read(start, 10);
      do_read(11'd2045, 5);

      // Zero-length readout
      do_read(11'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
